// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the cpu_sequencer slice: default widths, opcode
// encodings, instruction field positions and the sequencer state encoding.
// Optional feature macro used by this slice: OVF_FLAG_EN.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned ADDR_W  = 4;
   localparam int unsigned IMM_W   = 5;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned OPC_W   = 3;

   // Instruction layout: {opcode, rd, rs1, rs2_imm}; rs2 is the low nibble of rs2_imm
   localparam int unsigned OPC_MSB = 15;
   localparam int unsigned OPC_LSB = 13;
   localparam int unsigned RD_MSB  = 12;
   localparam int unsigned RD_LSB  = 9;
   localparam int unsigned RS1_MSB = 8;
   localparam int unsigned RS1_LSB = 5;
   localparam int unsigned RS2_MSB = 3;
   localparam int unsigned RS2_LSB = 0;
   localparam int unsigned IMM_LSB = 0;

   localparam logic [OPC_W-1:0] OP_LOAD    = 3'b000;
   localparam logic [OPC_W-1:0] OP_ADD     = 3'b001;
   localparam logic [OPC_W-1:0] OP_ADDI    = 3'b010;
   localparam logic [OPC_W-1:0] OP_SUB     = 3'b011;
   localparam logic [OPC_W-1:0] OP_SUBI    = 3'b100;
   localparam logic [OPC_W-1:0] OP_MUL     = 3'b101;
   localparam logic [OPC_W-1:0] OP_CLEAR   = 3'b110;
   localparam logic [OPC_W-1:0] OP_DISPLAY = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ1 = 3'd1,
      ST_READ2 = 3'd2,
      ST_WRITE = 3'd3,
      ST_CLR   = 3'd4,
      ST_DISP  = 3'd5
   } state_t;

   // Immediate-form arithmetic skips the second register read
   function automatic logic uses_imm(input logic [OPC_W-1:0] op);
      return (op == OP_ADDI) || (op == OP_SUBI);
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// -----------------------------------------------------------------------------
// cpu_alu
// Combinational ALU for the sequencer. All arithmetic is modulo 2^DATA_W.
// LOAD passes operand b (the zero-extended immediate) straight through.
// Ports:
//   op_i     opcode
//   a_i      first operand (rs1 value)
//   b_i      second operand (rs2 value or zero-extended immediate)
//   result_o write-back value
//   ovf_o    carry (ADD/ADDI), borrow (SUB/SUBI), upper product nonzero (MUL)
//            -- present only when OVF_FLAG_EN is defined
// -----------------------------------------------------------------------------
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
   input  logic [OPC_W-1:0]  op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] result_o
`ifdef OVF_FLAG_EN
   ,
   output logic              ovf_o
`endif
);

   // Widen intermediates only when the overflow flag needs the extra bits
`ifdef OVF_FLAG_EN
   localparam int unsigned SUM_W  = DATA_W + 1;
   localparam int unsigned PROD_W = 2 * DATA_W;
`else
   localparam int unsigned SUM_W  = DATA_W;
   localparam int unsigned PROD_W = DATA_W;
`endif

   logic [SUM_W-1:0]  sum;
   logic [SUM_W-1:0]  diff;
   logic [PROD_W-1:0] prod;

   always_comb begin
      sum  = SUM_W'(a_i) + SUM_W'(b_i);
      diff = SUM_W'(a_i) - SUM_W'(b_i);
      prod = PROD_W'(a_i) * PROD_W'(b_i);
      result_o = '0;
      unique case (op_i)
         OP_LOAD:          result_o = b_i;
         OP_ADD, OP_ADDI:  result_o = sum[DATA_W-1:0];
         OP_SUB, OP_SUBI:  result_o = diff[DATA_W-1:0];
         OP_MUL:           result_o = prod[DATA_W-1:0];
         default:          result_o = '0;
      endcase
   end

`ifdef OVF_FLAG_EN
   always_comb begin
      ovf_o = 1'b0;
      unique case (op_i)
         OP_ADD, OP_ADDI:  ovf_o = sum[SUM_W-1];
         OP_SUB, OP_SUBI:  ovf_o = diff[SUM_W-1];
         OP_MUL:           ovf_o = |prod[PROD_W-1:DATA_W];
         default:          ovf_o = 1'b0;
      endcase
   end
`endif

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Accepts one instruction per valid/ready handshake, sequences register-file
// reads, the ALU operation and the write-back, and latches DISPLAY results.
// Optional feature macro: OVF_FLAG_EN (adds the ovf output).
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   instr          {opcode[15:13], rd[12:9], rs1[8:5], rs2_imm[4:0]}
//   instr_valid    instruction offered
//   instr_ready    high only while idle
//   mem_addr       register index for read or write
//   mem_we         one-cycle write strobe
//   mem_wdata      write data
//   mem_clr        one-cycle clear-all strobe
//   mem_rdata      combinational read of register[mem_addr]
//   display_value  last DISPLAY result
//   display_valid  display_value holds a valid result
//   done           one-cycle pulse on instruction retire
//   ovf            overflow flag (OVF_FLAG_EN only)
// -----------------------------------------------------------------------------
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = cpu_pkg::DATA_W,
   parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
   parameter int unsigned IMM_W  = cpu_pkg::IMM_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_we,
   output logic [DATA_W-1:0]  mem_wdata,
   output logic               mem_clr,
   input  logic [DATA_W-1:0]  mem_rdata,
   output logic [DATA_W-1:0]  display_value,
   output logic               display_valid,
   output logic               done
`ifdef OVF_FLAG_EN
   ,
   output logic               ovf
`endif
);

   state_t               state_q, state_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [DATA_W-1:0]    a_q, a_d;
   logic [DATA_W-1:0]    b_q, b_d;
   logic [DATA_W-1:0]    disp_value_q, disp_value_d;
   logic                 disp_valid_q, disp_valid_d;

   logic [OPC_W-1:0]     opc;
   logic [OPC_W-1:0]     in_opc;
   logic [3:0]           rd_f, rs1_f, rs2_f;
   logic [IMM_W-1:0]     imm_f;
   logic [DATA_W-1:0]    alu_b;
   logic [DATA_W-1:0]    alu_result;

`ifdef OVF_FLAG_EN
   logic                 ovf_q, ovf_d;
   logic                 alu_ovf;
`endif

   assign opc    = instr_q[OPC_MSB:OPC_LSB];
   assign in_opc = instr[OPC_MSB:OPC_LSB];
   assign rd_f   = instr_q[RD_MSB:RD_LSB];
   assign rs1_f  = instr_q[RS1_MSB:RS1_LSB];
   assign rs2_f  = instr_q[RS2_MSB:RS2_LSB];
   assign imm_f  = instr_q[IMM_LSB +: IMM_W];

   // LOAD and the immediate forms take the zero-extended immediate as operand b
   assign alu_b = ((opc == OP_LOAD) || uses_imm(opc)) ? DATA_W'(imm_f) : b_q;

   cpu_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op_i     (opc),
      .a_i      (a_q),
      .b_i      (alu_b),
      .result_o (alu_result)
`ifdef OVF_FLAG_EN
      ,
      .ovf_o    (alu_ovf)
`endif
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         instr_q      <= '0;
         a_q          <= '0;
         b_q          <= '0;
         disp_value_q <= '0;
         disp_valid_q <= 1'b0;
`ifdef OVF_FLAG_EN
         ovf_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         instr_q      <= instr_d;
         a_q          <= a_d;
         b_q          <= b_d;
         disp_value_q <= disp_value_d;
         disp_valid_q <= disp_valid_d;
`ifdef OVF_FLAG_EN
         ovf_q        <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      instr_d      = instr_q;
      a_d          = a_q;
      b_d          = b_q;
      disp_value_d = disp_value_q;
      disp_valid_d = disp_valid_q;
`ifdef OVF_FLAG_EN
      ovf_d        = ovf_q;
`endif
      instr_ready  = 1'b0;
      mem_addr     = '0;
      mem_we       = 1'b0;
      mem_wdata    = '0;
      mem_clr      = 1'b0;
      done         = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Held low while reset is asserted so every output reads 0 in reset
            instr_ready = ~reset;
            if (instr_valid) begin
               instr_d = instr;
               unique case (in_opc)
                  OP_LOAD:    state_d = ST_WRITE;
                  OP_CLEAR:   state_d = ST_CLR;
                  OP_DISPLAY: state_d = ST_DISP;
                  default:    state_d = ST_READ1;
               endcase
            end
         end
         ST_READ1: begin
            mem_addr = ADDR_W'(rs1_f);
            a_d      = mem_rdata;
            state_d  = uses_imm(opc) ? ST_WRITE : ST_READ2;
         end
         ST_READ2: begin
            mem_addr = ADDR_W'(rs2_f);
            b_d      = mem_rdata;
            state_d  = ST_WRITE;
         end
         ST_WRITE: begin
            mem_addr  = ADDR_W'(rd_f);
            mem_we    = 1'b1;
            mem_wdata = alu_result;
            done      = 1'b1;
`ifdef OVF_FLAG_EN
            if (opc != OP_LOAD) begin
               ovf_d = alu_ovf;
            end
`endif
            state_d   = ST_IDLE;
         end
         ST_CLR: begin
            mem_clr      = 1'b1;
            done         = 1'b1;
            disp_value_d = '0;
            disp_valid_d = 1'b0;
`ifdef OVF_FLAG_EN
            ovf_d        = 1'b0;
`endif
            state_d      = ST_IDLE;
         end
         ST_DISP: begin
            mem_addr     = ADDR_W'(rd_f);
            disp_value_d = mem_rdata;
            disp_valid_d = 1'b1;
            done         = 1'b1;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign display_value = disp_value_q;
   assign display_valid = disp_valid_q;
`ifdef OVF_FLAG_EN
   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
// Directed and random instruction streams against a behavioural model of the
// instruction set. A simple 16x16 register file is modelled around the DUT.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

   localparam logic [2:0] T_LOAD = 3'd0, T_ADD = 3'd1, T_ADDI = 3'd2, T_SUB = 3'd3,
                          T_SUBI = 3'd4, T_MUL = 3'd5, T_CLEAR = 3'd6, T_DISP = 3'd7;

   logic        clock;
   logic        reset;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [3:0]  mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic        mem_clr;
   logic [15:0] mem_rdata;
   logic [15:0] display_value;
   logic        display_valid;
   logic        done;
`ifdef OVF_FLAG_EN
   logic        ovf;
`endif

   cpu_sequencer #(
      .DATA_W (16),
      .ADDR_W (4),
      .IMM_W  (5)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .mem_addr      (mem_addr),
      .mem_we        (mem_we),
      .mem_wdata     (mem_wdata),
      .mem_clr       (mem_clr),
      .mem_rdata     (mem_rdata),
      .display_value (display_value),
      .display_valid (display_valid),
      .done          (done)
`ifdef OVF_FLAG_EN
      ,
      .ovf           (ovf)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Register file driven by the DUT strobes
   logic [15:0] rf [16];
   assign mem_rdata = rf[mem_addr];
   always @(posedge clock) begin
      if (mem_clr) begin
         for (int i = 0; i < 16; i++) rf[i] <= '0;
      end else if (mem_we) begin
         rf[mem_addr] <= mem_wdata;
      end
   end

   // Reference model state
   logic [15:0] m_rf [16];
   logic [15:0] m_disp;
   logic        m_dvalid;
   logic        m_ovf;

   int unsigned passes = 0;
   int unsigned fails  = 0;
   int unsigned total  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] enc(input logic [2:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [4:0] imm);
      return {op, rd, rs1, imm};
   endfunction

   // Issue one instruction, then check the retire cycle and the state after it
   task automatic run_instr(input logic [15:0] ins);
      logic [2:0]  op;
      logic [3:0]  rd, rs1, rs2;
      int unsigned a, b, imm, r, lat, exp_lat, cyc;
      logic        wr, ovf_new;
      op  = ins[15:13];
      rd  = ins[12:9];
      rs1 = ins[8:5];
      rs2 = ins[3:0];
      imm = 32'(ins[4:0]);
      a   = 32'(m_rf[rs1]);
      b   = 32'(m_rf[rs2]);
      wr  = 1'b1;
      ovf_new = 1'b0;
      r   = 0;
      exp_lat = 3;
      case (op)
         T_LOAD:  begin r = imm; exp_lat = 1; end
         T_ADD:   begin r = a + b; ovf_new = (r > 65535); end
         T_ADDI:  begin r = a + imm; ovf_new = (r > 65535); exp_lat = 2; end
         T_SUB:   begin r = a + 65536 - b; ovf_new = (a < b); end
         T_SUBI:  begin r = a + 65536 - imm; ovf_new = (a < imm); exp_lat = 2; end
         T_MUL:   begin r = a * b; ovf_new = (r > 65535); end
         default: begin wr = 1'b0; exp_lat = 1; end
      endcase
      r = r % 65536;

      cyc = 0;
      while (instr_ready !== 1'b1 && cyc < 20) begin
         @(posedge clock); #1;
         cyc++;
      end
      chk("ready_before_issue", 32'(instr_ready), 32'd1);

      instr = ins;
      instr_valid = 1'b1;
      @(posedge clock); #1;
      instr_valid = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 10) begin
         chk("ready_low_busy", 32'(instr_ready), 32'd0);
         @(posedge clock); #1;
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("done_pulse", 32'(done), 32'd1);

      if (wr) begin
         chk("we", 32'(mem_we), 32'd1);
         chk("waddr", 32'(mem_addr), 32'(rd));
         chk("wdata", 32'(mem_wdata), r);
         m_rf[rd] = 16'(r);
         if (op != T_LOAD) m_ovf = ovf_new;
      end else if (op == T_CLEAR) begin
         chk("clr", 32'(mem_clr), 32'd1);
         chk("we_on_clear", 32'(mem_we), 32'd0);
         for (int i = 0; i < 16; i++) m_rf[i] = '0;
         m_disp = '0;
         m_dvalid = 1'b0;
         m_ovf = 1'b0;
      end else begin
         chk("disp_addr", 32'(mem_addr), 32'(rd));
         chk("we_on_disp", 32'(mem_we), 32'd0);
         m_disp = m_rf[rd];
         m_dvalid = 1'b1;
      end

      @(posedge clock); #1;
      chk("ready_after", 32'(instr_ready), 32'd1);
      chk("done_single", 32'(done), 32'd0);
      chk("display_value", 32'(display_value), 32'(m_disp));
      chk("display_valid", 32'(display_valid), 32'(m_dvalid));
      chk("rf_rd", 32'(rf[rd]), 32'(m_rf[rd]));
`ifdef OVF_FLAG_EN
      chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned accepts, dones;
      logic [31:0] rnd;
      logic [15:0] pre9;

      reset = 1'b1;
      instr = '0;
      instr_valid = 1'b0;
      m_disp = '0;
      m_dvalid = 1'b0;
      m_ovf = 1'b0;
      for (int i = 0; i < 16; i++) m_rf[i] = '0;

      // Reset state
      #2;
      chk("rst_ready", 32'(instr_ready), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_clr", 32'(mem_clr), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_dvalue", 32'(display_value), 32'd0);
      chk("rst_dvalid", 32'(display_valid), 32'd0);
      @(posedge clock); #3;
      reset = 1'b0;
      @(posedge clock); #1;
      chk("ready_after_reset", 32'(instr_ready), 32'd1);

      // Initialise the register file, then the directed plan
      run_instr(enc(T_CLEAR, 4'd0, 4'd0, 5'd0));
      run_instr(enc(T_LOAD, 4'd3, 4'd0, 5'd21));
      chk("load_r3", 32'(rf[3]), 32'h15);
      run_instr(enc(T_SUBI, 4'd1, 4'd0, 5'd1));
      chk("r1_ffff", 32'(rf[1]), 32'hFFFF);
      run_instr(enc(T_LOAD, 4'd2, 4'd0, 5'd2));
      run_instr(enc(T_ADD, 4'd4, 4'd1, 5'd2));
      chk("add_wrap", 32'(rf[4]), 32'h0001);
`ifdef OVF_FLAG_EN
      chk("add_carry", 32'(ovf), 32'd1);
`endif
      run_instr(enc(T_LOAD, 4'd5, 4'd0, 5'd7));
      run_instr(enc(T_SUBI, 4'd5, 4'd5, 5'd9));
      chk("subi_alias", 32'(rf[5]), 32'hFFFE);
      run_instr(enc(T_MUL, 4'd8, 4'd1, 5'd2));
      chk("mul_low", 32'(rf[8]), 32'hFFFE);
      run_instr(enc(T_ADD, 4'd10, 4'd10, 5'd10));
      run_instr(enc(T_DISP, 4'd4, 4'd0, 5'd0));
      chk("disp_r4", 32'(display_value), 32'h0001);
      run_instr(enc(T_CLEAR, 4'd0, 4'd0, 5'd0));
      chk("clear_dvalid", 32'(display_valid), 32'd0);

      // Held instr_valid across three ADDs with rd == rs1
      run_instr(enc(T_LOAD, 4'd6, 4'd0, 5'd1));
      run_instr(enc(T_LOAD, 4'd7, 4'd0, 5'd3));
      instr = enc(T_ADD, 4'd6, 4'd6, 5'd7);
      instr_valid = 1'b1;
      accepts = 0;
      dones = 0;
      for (int c = 0; c < 40 && (accepts < 3 || dones < 3); c++) begin
         if (instr_ready === 1'b1 && instr_valid) accepts++;
         @(posedge clock); #1;
         if (accepts == 3) instr_valid = 1'b0;
         if (done === 1'b1) dones++;
      end
      for (int k = 0; k < 3; k++) begin
         m_ovf = (32'(m_rf[6]) + 32'(m_rf[7])) > 65535;
         m_rf[6] = m_rf[6] + m_rf[7];
      end
      @(posedge clock); #1;
      chk("held_accepts", accepts, 32'd3);
      chk("held_dones", dones, 32'd3);
      chk("held_r6", 32'(rf[6]), 32'(m_rf[6]));
      chk("held_idle", 32'(instr_ready), 32'd1);

      // Reset asserted in READ2 of a MUL aborts it
      run_instr(enc(T_LOAD, 4'd9, 4'd0, 5'd17));
      run_instr(enc(T_DISP, 4'd9, 4'd0, 5'd0));
      pre9 = m_rf[9];
      instr = enc(T_MUL, 4'd9, 4'd7, 5'd6);
      instr_valid = 1'b1;
      @(posedge clock); #1;
      instr_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      chk("abort_we", 32'(mem_we), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_addr", 32'(mem_addr), 32'd0);
      chk("abort_ready", 32'(instr_ready), 32'd0);
      chk("abort_dvalue", 32'(display_value), 32'd0);
      chk("abort_dvalid", 32'(display_valid), 32'd0);
      m_disp = '0;
      m_dvalid = 1'b0;
      m_ovf = 1'b0;
      @(posedge clock); #1;
      chk("abort_we_held", 32'(mem_we), 32'd0);
      #2;
      reset = 1'b0;
      @(posedge clock); #1;
      chk("abort_idle", 32'(instr_ready), 32'd1);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_r9", 32'(rf[9]), 32'(pre9));
`ifdef OVF_FLAG_EN
      chk("abort_ovf", 32'(ovf), 32'd0);
`endif

      // Random instruction stream
      for (int n = 0; n < 60; n++) begin
         rnd = $urandom;
         run_instr(rnd[15:0]);
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Instruction issuer and initiator for the 16x16 register-file memory. Accepts one 16-bit instruction per valid/ready handshake and decodes it. Drives the register file's write, clear and asynchronous-read port over a multi-cycle FSM. Performs the ALU operation, writes the result back, and latches the DISPLAY result for the board display logic.

Parameters:
DATA_W, 16, register/result width
ADDR_W, 4, register index width (16 registers)
IMM_W, 5, immediate width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
instr  in  16  {opcode[15:13], rd[12:9], rs1[8:5], rs2_imm[4:0]}; rs2 = rs2_imm[3:0]
instr_valid  in  1  instruction offered
instr_ready  out  1  high only in IDLE
mem_addr  out  4  register index for read or write
mem_we  out  1  write strobe, one cycle
mem_wdata  out  16  write data
mem_clr  out  1  clear-all strobe, one cycle
mem_rdata  in  16  combinational read of register[mem_addr]
display_value  out  16  last DISPLAY result
display_valid  out  1  display_value holds a valid result
done  out  1  one-cycle pulse on instruction retire

Behaviour:
- Opcodes (3 bit): LOAD 000, ADD 001, ADDI 010, SUB 011, SUBI 100, MUL 101, CLEAR 110, DISPLAY 111.
- Reset (async):
  - All outputs 0; FSM to IDLE; operand regs A/B = 0.
  - Reset mid-instruction aborts it: no write, no done.
- FSM states: IDLE, READ1, READ2, WRITE, CLR, DISP.
- IDLE:
  - instr_ready=1.
  - On instr_valid at the edge, latch instr.
  - Next state: LOAD->WRITE; ADD/SUB/MUL/ADDI/SUBI->READ1; CLEAR->CLR; DISPLAY->DISP.
- READ1:
  - mem_addr=rs1; A<=mem_rdata.
  - Next state: ADDI/SUBI->WRITE, else READ2.
- READ2: mem_addr=rs2; B<=mem_rdata; next WRITE.
- WRITE:
  - mem_addr=rd, mem_we=1, done=1; next IDLE.
  - mem_wdata by opcode:
    - LOAD: zero-extended imm.
    - ADD: A+B.
    - SUB: A-B.
    - ADDI: A+zext(imm).
    - SUBI: A-zext(imm).
    - MUL: low 16 bits of A*B.
  - All arithmetic is modulo 2^16.
- CLR:
  - mem_clr=1, done=1; display_valid<=0; display_value<=0; next IDLE.
- DISP:
  - mem_addr=rd.
  - display_value<=mem_rdata; display_valid<=1; done=1; next IDLE.
- Outside active states: mem_addr=0, mem_we=0, mem_clr=0, mem_wdata=0.
- Latency from accept edge to done pulse:
  - LOAD/CLEAR/DISPLAY: 1 cycle.
  - ADDI/SUBI: 2 cycles.
  - ADD/SUB/MUL: 3 cycles.
- Back-to-back: the next instruction is accepted the cycle after done; instr_ready is low throughout execution. Held instr_valid is not re-consumed.
- Register aliasing: rd==rs1==rs2 is legal. Reads complete before the WRITE edge, so the old values are used.
- display_value is unchanged by every instruction except DISPLAY and CLEAR.

Optional Feature:
OVF_FLAG_EN
- Defined:
  - Extra output ovf (1 bit, reset 0), updated at the WRITE edge of ADD/ADDI/SUB/SUBI/MUL.
  - ovf = carry-out for ADD/ADDI; borrow for SUB/SUBI; product upper 16 bits nonzero for MUL.
  - LOAD leaves ovf unchanged; CLEAR clears it.
- Undefined: no ovf port; behaviour otherwise identical.

Decomposition:
- Package cpu_pkg: opcode localparams (LOAD..DISPLAY), state enum encoding, instruction field bit positions, DATA_W/ADDR_W/IMM_W defaults.
- Sub-module cpu_alu: combinational; inputs op, A, B/imm; outputs result and, under OVF_FLAG_EN, ovf.
- FSM and operand registers stay in cpu_sequencer.

Test Plan:
- Reset, then LOAD rd=3 imm=21 -> one cycle later: mem_we=1, mem_addr=3, mem_wdata=0x0015, done=1; then instr_ready=1.
- Model R1=0xFFFF, R2=0x0002; ADD rd=4 rs1=1 rs2=2 -> done 3 cycles after accept, mem_wdata=0x0001; ovf=1 if OVF_FLAG_EN.
- R5=7; SUBI rd=5 rs1=5 imm=9 -> mem_wdata=0xFFFE at cycle 2; MUL R1*R2 -> 0xFFFE.
- DISPLAY rd=4 -> display_value=0x0001, display_valid=1. Then CLEAR -> mem_clr pulse, display_valid=0, display_value=0.
- instr_valid held high for 3 ADDs -> each accepted only when instr_ready=1; exactly 3 done pulses, no lost or duplicated writes.
- Assert reset during READ2 of MUL -> no mem_we, no done; outputs 0; FSM IDLE next cycle after reset release.
